// File: rtl/maxnet_input_loader_pkg.sv
// Shared constants and state encoding for the MaxNet input loader.
// The controller FSM and the buffer datapath both take their defaults from here.
package maxnet_input_loader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_DEF      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_START  = 3'd3,
        ST_RUN    = 3'd4
    } state_e;

    // Upstream words are only taken while a frame is being (or about to be) filled.
    function automatic logic takes_words(state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD_W) || (s == ST_LOAD_X);
    endfunction

endpackage

// File: rtl/maxnet_input_loader_if.sv
// Word-stream handshake plus buffer/control bus between upstream, the loader and the MaxNet controller.
// master = upstream/controller side, slave = loader side.
interface maxnet_input_loader_if #(
    parameter int DATA_W = maxnet_input_loader_pkg::DATA_W_DEF,
    parameter int N      = maxnet_input_loader_pkg::N_DEF
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    reuse_w;
    logic                    is_finished;
    logic                    start;
    logic [N*DATA_W-1:0]     x_flat;
    logic [N*N*DATA_W-1:0]   w_flat;
    logic                    busy;

    modport master (
        output in_valid, in_data, reuse_w, is_finished,
        input  in_ready, start, x_flat, w_flat, busy
    );

    modport slave (
        input  in_valid, in_data, reuse_w, is_finished,
        output in_ready, start, x_flat, w_flat, busy
    );

endinterface

// File: rtl/maxnet_input_loader_word_buffer.sv
// Register file with one indexed write port and every word visible on a flat read bus.
// Write lands on the next rising edge; no backpressure, the caller qualifies we_i.
module maxnet_input_loader_word_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_W-1:0]       din_i,
    output logic [DEPTH*DATA_W-1:0] flat_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign flat_o[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/maxnet_input_loader.sv
// Fills the N*N weight and N input buffers from a word stream, pulses start, then holds until is_finished.
// start follows the last accepted x word by one cycle; in_ready is registered and low during START/RUN.
module maxnet_input_loader
    import maxnet_input_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    maxnet_input_loader_if.slave bus
);

    localparam int CNT_W = $clog2(N*N);
    localparam int XA_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(N*N - 1);
    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               rdy_q, rdy_d;

    logic               accept;
    logic               w_we;
    logic               x_we;
    logic [CNT_W-1:0]   buf_addr;

    assign accept = bus.in_valid & rdy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        w_we    = 1'b0;
        x_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    cnt_d  = CNT_ONE;
                    if (bus.reuse_w) begin
                        x_we    = 1'b1;
                        state_d = ST_LOAD_X;
                    end else begin
                        w_we    = 1'b1;
                        state_d = ST_LOAD_W;
                    end
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    w_we = 1'b1;
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    x_we = 1'b1;
                    if (cnt_q == X_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A level already high here ends RUN immediately; the controller clears it on start.
                if (bus.is_finished) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Ready is registered from the next state so it is low throughout reset and START/RUN.
    assign rdy_d = takes_words(state_d);

    // The first word of a frame is always slot 0, independent of cnt.
    assign buf_addr = (state_q == ST_IDLE) ? '0 : cnt_q;

    maxnet_input_loader_word_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (N*N)
    ) u_w_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (w_we),
        .addr_i (buf_addr),
        .din_i  (bus.in_data),
        .flat_o (bus.w_flat)
    );

    maxnet_input_loader_word_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (N)
    ) u_x_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (x_we),
        .addr_i (buf_addr[XA_W-1:0]),
        .din_i  (bus.in_data),
        .flat_o (bus.x_flat)
    );

    assign bus.in_ready = rdy_q;
    assign bus.start    = (state_q == ST_START);
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Bench for maxnet_input_loader: frame-level reference model compared every cycle,
// directed frames with hand-computed literals, then randomized frames with gaps and noise.
module tb_maxnet_input_loader;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int NW = NN * NN;

    localparam int PH_WAIT = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_GO   = 2;
    localparam int PH_RUN  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxnet_input_loader_if #(.DATA_W(DW), .N(NN)) bus ();

    maxnet_input_loader #(.DATA_W(DW), .N(NN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of words; word k goes to w[k] for k < N*N and to
    // x[k-N*N] afterwards, or to x[k] for a reuse frame. Buffers persist until reset.
    logic [DW-1:0] m_w [NW];
    logic [DW-1:0] m_x [NN];
    int            m_phase;
    int            m_k;
    logic          m_reuse;
    logic          m_busy;
    logic          m_ready;

    wire m_acc = bus.in_valid && m_ready;

    function automatic int frame_len(input logic r);
        return r ? NN : NW + NN;
    endfunction

    task automatic store(input logic r, input int k, input logic [DW-1:0] d);
        if (r)           m_x[k]      <= d;
        else if (k < NW) m_w[k]      <= d;
        else             m_x[k - NW] <= d;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= PH_WAIT;
            m_k     <= 0;
            m_reuse <= 1'b0;
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            for (int i = 0; i < NW; i++) m_w[i] <= '0;
            for (int i = 0; i < NN; i++) m_x[i] <= '0;
        end else begin
            case (m_phase)
                PH_WAIT: begin
                    m_ready <= 1'b1;
                    if (m_acc) begin
                        m_reuse <= bus.reuse_w;
                        m_busy  <= 1'b1;
                        m_k     <= 1;
                        m_phase <= PH_LOAD;
                        store(bus.reuse_w, 0, bus.in_data);
                    end
                end
                PH_LOAD: begin
                    if (m_acc) begin
                        store(m_reuse, m_k, bus.in_data);
                        if (m_k + 1 == frame_len(m_reuse)) begin
                            m_phase <= PH_GO;
                            m_ready <= 1'b0;
                            m_k     <= 0;
                        end else begin
                            m_k <= m_k + 1;
                        end
                    end
                end
                PH_GO: m_phase <= PH_RUN;
                default: begin
                    if (bus.is_finished) begin
                        m_phase <= PH_WAIT;
                        m_busy  <= 1'b0;
                        m_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    function automatic logic [NN*DW-1:0] exp_x();
        logic [NN*DW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = m_x[i];
        return r;
    endfunction

    function automatic logic [NW*DW-1:0] exp_w();
        logic [NW*DW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = m_w[i];
        return r;
    endfunction

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, m_ready);
        chk("start",    bus.start,    m_phase == PH_GO);
        chk("busy",     bus.busy,     m_busy);
        chk("x_flat",   bus.x_flat,   exp_x());
        chk("w_flat",   bus.w_flat,   exp_w());
    end

    // Stimulus
    logic [DW-1:0]      tw [NW];
    logic [DW-1:0]      tx [NN];
    logic [NW*DW-1:0]   lit_w;
    logic [NN*DW-1:0]   lit_x;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic r);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.reuse_w  = r;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            cycle();
        end
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.reuse_w  = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_full(input bit gaps);
        for (int k = 0; k < NW + NN; k++) begin
            send((k < NW) ? tw[k] : tx[k - NW], 1'b0);
            if (gaps && k < NW + NN - 1) idle(1);
        end
    endtask

    task automatic run_finish(input int wait_n, input bit noise);
        for (int i = 0; i < wait_n; i++) begin
            bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data  = $urandom;
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("busy_before_finish", bus.busy, 1'b1);
        bus.is_finished = 1'b1;
        cycle();
        bus.is_finished = 1'b0;
        chk("busy_after_finish", bus.busy, 1'b0);
        chk("ready_after_finish", bus.in_ready, 1'b1);
    endtask

    function automatic logic [NW*DW-1:0] pack_tw();
        logic [NW*DW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = tw[i];
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.reuse_w     = 1'b0;
        bus.is_finished = 1'b0;
        #1 rst = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;

        // Reset state, in_ready rises only after the first edge following release
        @(negedge clk);
        chk("rst_ready_low", bus.in_ready, 1'b0);
        chk("rst_busy",      bus.busy,     1'b0);
        chk("rst_w_flat",    bus.w_flat,   '0);
        cycle();
        chk("ready_after_release", bus.in_ready, 1'b1);

        // Test 1: back-to-back frame, then valid noise during START/RUN
        for (int i = 0; i < NW; i++) tw[i] = 32'h100 + i;
        tx[0] = 32'd5; tx[1] = 32'd3; tx[2] = 32'd9; tx[3] = 32'd1;
        lit_x = {32'd1, 32'd9, 32'd3, 32'd5};
        lit_w = pack_tw();
        send_full(1'b0);
        chk("t1_start",       bus.start,    1'b1);
        chk("t1_ready_start", bus.in_ready, 1'b0);
        chk("t1_x_flat",      bus.x_flat,   lit_x);
        chk("t1_w_word5",     bus.w_flat[5*DW +: DW], 32'h105);
        cycle();
        chk("t1_start_once",  bus.start,    1'b0);
        run_finish(6, 1'b1);
        chk("t1_x_stable",    bus.x_flat,   lit_x);
        chk("t1_w_stable",    bus.w_flat,   lit_w);

        // Test 2: same frame with valid toggling every other cycle
        send_full(1'b1);
        chk("t2_start",  bus.start,  1'b1);
        chk("t2_x_flat", bus.x_flat, lit_x);
        chk("t2_w_flat", bus.w_flat, lit_w);
        run_finish(2, 1'b0);

        // Test 3: reuse weights, reuse_w only sampled on the first word
        send(32'd2, 1'b1);
        send(32'd8, 1'b0);
        send(32'd4, 1'b0);
        send(32'd6, 1'b0);
        chk("t3_start",  bus.start,  1'b1);
        chk("t3_x_flat", bus.x_flat, {32'd6, 32'd4, 32'd8, 32'd2});
        chk("t3_w_kept", bus.w_flat, lit_w);
        run_finish(3, 1'b0);

        // Test 4: asynchronous reset mid weight frame, then a fresh frame
        for (int i = 0; i < 10; i++) send($urandom, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t4_busy_async",  bus.busy,     1'b0);
        chk("t4_ready_async", bus.in_ready, 1'b0);
        chk("t4_start_async", bus.start,    1'b0);
        chk("t4_x_async",     bus.x_flat,   '0);
        chk("t4_w_async",     bus.w_flat,   '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        for (int i = 0; i < NW; i++) tw[i] = 32'h200 + i;
        for (int i = 0; i < NN; i++) tx[i] = $urandom;
        lit_w = pack_tw();
        send_full(1'b0);
        chk("t4_start",  bus.start,  1'b1);
        chk("t4_w_flat", bus.w_flat, lit_w);
        chk("t4_x_word3", bus.x_flat[3*DW +: DW], tx[3]);
        run_finish(2, 1'b0);

        // Test 5: is_finished ignored while loading; finish 7 cycles into RUN
        bus.is_finished = 1'b1;
        for (int i = 0; i < NW; i++) send($urandom, 1'b0);
        bus.is_finished = 1'b0;
        chk("t5_busy_loading", bus.busy, 1'b1);
        for (int i = 0; i < NN; i++) send($urandom, 1'b0);
        chk("t5_start", bus.start, 1'b1);
        run_finish(7, 1'b0);

        // Randomized frames: random reuse, data, gaps, run length and valid noise
        for (int f = 0; f < 10; f++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            for (int k = 0; k < frame_len(r); k++) begin
                send($urandom, (k == 0) ? r : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0 && k < frame_len(r) - 1) begin
                    bus.is_finished = 1'($urandom_range(0, 1));
                    idle($urandom_range(1, 3));
                    bus.is_finished = 1'b0;
                end
            end
            chk("rnd_start", bus.start, 1'b1);
            run_finish($urandom_range(1, 8), 1'b1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
